// File: rtl/wide_cmd_pkg.sv
// Shared types and constants for wide_cmd_responder: FSM states, opcodes,
// status codes, 64-bit word layout and the byte-XOR check helper.
package wide_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADOP   = 8'hEE;
  localparam logic [7:0] ST_BADADDR = 8'hEA;
  localparam logic [7:0] ST_BADCHK  = 8'hEC;

  // Opcode (command) and status (response) share the top byte.
  localparam int F_OP_LSB   = 56;
  localparam int F_TAG_LSB  = 48;
  localparam int F_ADDR_LSB = 40;
  localparam int F_CHK_LSB  = 32;
  localparam int F_DATA_LSB = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  tag;
    logic [7:0]  addr;
    logic [7:0]  chk;
    logic [31:0] data;
  } wide_word_t;

  // XOR of the seven bytes other than the check byte.
  function automatic logic [7:0] word_xor(input logic [63:0] w);
    return w[F_OP_LSB +: 8] ^ w[F_TAG_LSB +: 8] ^ w[F_ADDR_LSB +: 8] ^
           w[F_DATA_LSB + 24 +: 8] ^ w[F_DATA_LSB + 16 +: 8] ^
           w[F_DATA_LSB + 8 +: 8] ^ w[F_DATA_LSB +: 8];
  endfunction

endpackage

// File: rtl/wide_cmd_regfile.sv
// NUM_REGS x 32-bit register file: synchronous write port, combinational
// read port, cleared by the asynchronous active-low reset.
module wide_cmd_regfile #(
  parameter int NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [7:0]  rd_addr_i,
  output logic [31:0] rd_data_o
);

  logic [31:0] mem_q [NUM_REGS];

  // Storage: clear on reset, single-entry write when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_i && (wr_addr_i == 8'(i))) begin
          mem_q[i] <= wr_data_i;
        end
      end
    end
  end

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    rd_data_o = 32'h0000_0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data_o = rd_data_o | ((rd_addr_i == 8'(i)) ? mem_q[i] : 32'h0000_0000);
    end
  end

endmodule

// File: rtl/wide_cmd_responder.sv
// 64-bit command/response register-access responder (IDLE -> EXEC -> RESP).
// Define WIDE_CMD_CHECKSUM_EN to verify command check bytes and fill response check bytes.
import wide_cmd_pkg::*;

module wide_cmd_responder #(
  parameter int NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        reg_wr_pulse,
  output logic [15:0] cmd_count
);

  localparam logic [8:0] NREGS_W = 9'(NUM_REGS);

  state_t      state_q;
  wide_word_t  cmd_q;
  logic        tready_q;
  logic        tvalid_q;
  logic        pulse_q;
  logic [63:0] tdata_q;
  logic [15:0] cmd_count_q;
  logic [15:0] cmd_count_d;

  logic [7:0]  status_s;
  logic [7:0]  chk_out_s;
  logic [31:0] rdata_s;
  logic [31:0] rd_data_s;
  logic [63:0] resp_s;
  logic        wr_en_s;
  logic        chk_bad_s;
  logic        op_bad_s;
  logic        addr_bad_s;
  logic        resp_hs_s;

  wide_cmd_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (cmd_q.addr),
    .wr_data_i (cmd_q.data),
    .rd_addr_i (cmd_q.addr),
    .rd_data_o (rd_data_s)
  );

`ifdef WIDE_CMD_CHECKSUM_EN
  assign chk_bad_s = (cmd_q.chk != word_xor(cmd_q));
  assign chk_out_s = word_xor({status_s, cmd_q.tag, cmd_q.addr, 8'h00, rdata_s});
`else
  logic chk_unused_s;
  assign chk_unused_s = ^cmd_q.chk;
  assign chk_bad_s    = 1'b0;
  assign chk_out_s    = 8'h00;
`endif

  assign addr_bad_s = ({1'b0, cmd_q.addr} >= NREGS_W);
  assign resp_hs_s  = (state_q == S_RESP) && tvalid_q && m_axis_tready;

  // Opcode legality.
  always_comb begin
    case (cmd_q.op)
      OP_WRITE, OP_READ, OP_PING: op_bad_s = 1'b0;
      default:                    op_bad_s = 1'b1;
    endcase
  end

  // Command decode with error priority check > opcode > address.
  always_comb begin
    status_s = ST_OK;
    rdata_s  = 32'h0000_0000;
    wr_en_s  = 1'b0;
    if (chk_bad_s) begin
      status_s = ST_BADCHK;
    end else if (op_bad_s) begin
      status_s = ST_BADOP;
    end else if (cmd_q.op == OP_PING) begin
      rdata_s = cmd_q.data;
    end else if (addr_bad_s) begin
      status_s = ST_BADADDR;
    end else if (cmd_q.op == OP_WRITE) begin
      wr_en_s = (state_q == S_EXEC);
      rdata_s = cmd_q.data;
    end else begin
      rdata_s = rd_data_s;
    end
  end

  // Response word assembly.
  always_comb begin
    resp_s                     = 64'h0;
    resp_s[F_OP_LSB +: 8]      = status_s;
    resp_s[F_TAG_LSB +: 8]     = cmd_q.tag;
    resp_s[F_ADDR_LSB +: 8]    = cmd_q.addr;
    resp_s[F_CHK_LSB +: 8]     = chk_out_s;
    resp_s[F_DATA_LSB +: 32]   = rdata_s;
  end

  // Completed-response counter next state, wrapping at 16 bits.
  always_comb begin
    cmd_count_d = resp_hs_s ? (cmd_count_q + 16'd1) : cmd_count_q;
  end

  // Main FSM with registered stream outputs and write pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= 64'h0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tready_q <= 1'b1;
          if (s_axis_tvalid && tready_q) begin
            cmd_q    <= s_axis_tdata;
            tready_q <= 1'b0;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          tdata_q <= resp_s;
          pulse_q <= wr_en_s;
          state_q <= S_RESP;
        end
        S_RESP: begin
          // tvalid rises one edge after the response is registered.
          if (!tvalid_q) begin
            tvalid_q <= 1'b1;
          end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
            tready_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          tready_q <= 1'b0;
          tvalid_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  // Completed-response counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_count_q <= 16'h0000;
    end else begin
      cmd_count_q <= cmd_count_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign reg_wr_pulse  = pulse_q;
  assign cmd_count     = cmd_count_q;

endmodule

// File: tb/tb_wide_cmd_responder.sv
// Directed, table-driven bench for wide_cmd_responder (NUM_REGS = 16),
// with hand-written stall, reset-during-response and counter-wrap sequences.
module tb_wide_cmd_responder;

  localparam int NUM_REGS = 16;
  localparam int NVEC     = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] s_tdata = 64'h0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        reg_wr_pulse;
  logic [15:0] cmd_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  tag;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  st;
    logic [31:0] rdata;
    int          pulses;
  } vec_t;

  vec_t vecs [NVEC];

  wide_cmd_responder #(.NUM_REGS(NUM_REGS)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .reg_wr_pulse  (reg_wr_pulse),
    .cmd_count     (cmd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bx(input logic [63:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (b != 4) x = x ^ w[b*8 +: 8];
    end
    return x;
  endfunction

  function automatic logic [63:0] mk_word(input logic [7:0] hi, input logic [7:0] tag,
                                          input logic [7:0] addr, input logic [31:0] data);
    logic [63:0] w;
    w = {hi, tag, addr, 8'h00, data};
`ifdef WIDE_CMD_CHECKSUM_EN
    w[39:32] = bx(w);
`endif
    return w;
  endfunction

  task automatic do_cmd(input logic [63:0] cmd, output logic [63:0] resp,
                        output int pulses, output int lat);
    int g;
    resp   = 64'h0;
    pulses = 0;
    lat    = 0;
    @(negedge clk);
    s_tdata  = cmd;
    s_tvalid = 1'b1;
    g = 0;
    while (!s_tready && g < 20) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 20) begin
      errors++;
      $display("FAIL accept_timeout actual=%0d required=<20", g);
    end
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    while (!m_tvalid && lat < 20) begin
      if (reg_wr_pulse) pulses++;
      @(negedge clk);
      lat++;
    end
    resp = m_tdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] resp;
    logic [63:0] held;
    logic [63:0] first_resp;
    logic [63:0] second_resp;
    int p;
    int lat;
    int g;
    int stall_bad;

    vecs[0] = '{8'h01, 8'h5A, 8'h03, 32'hDEADBEEF, 8'h00, 32'hDEADBEEF, 1};
    vecs[1] = '{8'h02, 8'h11, 8'h03, 32'h00000000, 8'h00, 32'hDEADBEEF, 0};
    vecs[2] = '{8'h02, 8'h22, 8'h04, 32'h00000000, 8'h00, 32'h00000000, 0};
    vecs[3] = '{8'h02, 8'h33, 8'h10, 32'h00000000, 8'hEA, 32'h00000000, 0};
    vecs[4] = '{8'h7F, 8'h44, 8'h03, 32'h12345678, 8'hEE, 32'h00000000, 0};
    vecs[5] = '{8'h03, 8'h55, 8'hFF, 32'hCAFEF00D, 8'h00, 32'hCAFEF00D, 0};
    vecs[6] = '{8'h01, 8'h66, 8'h0F, 32'h00000001, 8'h00, 32'h00000001, 1};
    vecs[7] = '{8'h02, 8'h67, 8'h0F, 32'h00000000, 8'h00, 32'h00000001, 0};
    vecs[8] = '{8'h01, 8'h68, 8'h10, 32'h11111111, 8'hEA, 32'h00000000, 0};
    vecs[9] = '{8'h00, 8'h69, 8'h20, 32'h00000000, 8'hEE, 32'h00000000, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    check64("rst_tready", {63'h0, s_tready}, 64'h0);
    check64("rst_tvalid", {63'h0, m_tvalid}, 64'h0);
    check64("rst_tdata", m_tdata, 64'h0);
    check64("rst_pulse", {63'h0, reg_wr_pulse}, 64'h0);
    check64("rst_count", {48'h0, cmd_count}, 64'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check64("tready_after_rst", {63'h0, s_tready}, 64'h1);

    first_resp  = 64'h0;
    second_resp = 64'h0;
    for (int i = 0; i < NVEC; i++) begin
      do_cmd(mk_word(vecs[i].op, vecs[i].tag, vecs[i].addr, vecs[i].data), resp, p, lat);
      if (i == 0) first_resp = resp;
      if (i == 1) second_resp = resp;
      check64($sformatf("vec%0d_resp", i), resp,
              mk_word(vecs[i].st, vecs[i].tag, vecs[i].addr, vecs[i].rdata));
      check64($sformatf("vec%0d_pulses", i), 64'(p), 64'(vecs[i].pulses));
      check64($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check64($sformatf("vec%0d_count", i), {48'h0, cmd_count}, 64'(i + 1));
    end

`ifndef WIDE_CMD_CHECKSUM_EN
    check64("write_literal", first_resp, 64'h005A0300DEADBEEF);
    check64("read_literal", second_resp, 64'h00110300DEADBEEF);
`else
    do_cmd(64'h0301020000000000, resp, p, lat);
    check64("ping_chk_ok", resp, 64'h0001020300000000);
    do_cmd(64'h0301020100000000, resp, p, lat);
    check64("ping_chk_bad", resp, 64'hEC0102EF00000000);
    do_cmd(mk_word(8'h7F, 8'h70, 8'h40, 32'h0) ^ 64'h0000_0000_8000_0000, resp, p, lat);
    check64("chk_over_op_status", {56'h0, resp[63:56]}, 64'hEC);
`endif

    // Stalled response with a queued command behind it.
    m_tready = 1'b0;
    @(negedge clk);
    s_tdata  = mk_word(8'h02, 8'h77, 8'h03, 32'h0);
    s_tvalid = 1'b1;
    g = 0;
    while (!s_tready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    s_tdata = mk_word(8'h03, 8'h78, 8'h09, 32'h0BADF00D);
    g = 0;
    while (!m_tvalid && g < 20) begin
      @(negedge clk);
      g++;
    end
    held = m_tdata;
    check64("stall_resp", held, mk_word(8'h00, 8'h77, 8'h03, 32'hDEADBEEF));
    stall_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!m_tvalid || (m_tdata !== held) || s_tready) stall_bad++;
    end
    check64("stall_hold", 64'(stall_bad), 64'd0);
    m_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check64("stall_hs_tvalid", {63'h0, m_tvalid}, 64'h0);
    check64("queued_ready", {63'h0, s_tready}, 64'h1);
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    check64("queued_accepted", {63'h0, s_tready}, 64'h0);
    g = 0;
    while (!m_tvalid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check64("queued_resp", m_tdata, mk_word(8'h00, 8'h78, 8'h09, 32'h0BADF00D));
    @(posedge clk);
    @(negedge clk);
    check64("count_after_stall", {48'h0, cmd_count}, 64'(NVEC + 2
`ifdef WIDE_CMD_CHECKSUM_EN
      + 3
`endif
      ));

    // Reset pulsed while a WRITE response is pending.
    m_tready = 1'b0;
    @(negedge clk);
    s_tdata  = mk_word(8'h01, 8'h80, 8'h05, 32'hA5A5A5A5);
    s_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
    g = 0;
    while (!m_tvalid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check64("pre_rst_tvalid", {63'h0, m_tvalid}, 64'h1);
    rst = 1'b0;
    #1;
    check64("midrst_tvalid", {63'h0, m_tvalid}, 64'h0);
    check64("midrst_tready", {63'h0, s_tready}, 64'h0);
    check64("midrst_count", {48'h0, cmd_count}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    m_tready = 1'b1;
    do_cmd(mk_word(8'h02, 8'h81, 8'h05, 32'h0), resp, p, lat);
    check64("post_rst_reg5", resp, mk_word(8'h00, 8'h81, 8'h05, 32'h0));
    do_cmd(mk_word(8'h02, 8'h82, 8'h03, 32'h0), resp, p, lat);
    check64("post_rst_reg3", resp, mk_word(8'h00, 8'h82, 8'h03, 32'h0));
    check64("post_rst_count", {48'h0, cmd_count}, 64'd2);

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.cmd_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.cmd_count_q;
    check64("count_preset", {48'h0, cmd_count}, 64'hFFFF);
    do_cmd(mk_word(8'h03, 8'h90, 8'h00, 32'h1), resp, p, lat);
    check64("count_wrap", {48'h0, cmd_count}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
